snoop_bus_arbiter: RTL and testbench

- Responder end of the shared coherence bus that the four per-processor caches use to issue requests.
- Each cache raises a request carrying its bus operation and address.
- The arbiter:
  - grants one cache by round-robin;
  - broadcasts the snoop to the other three caches and collects their shared/dirty responses;
  - fetches from memory when no cache holds dirty data;
  - returns a one-cycle completion to the requester.
- Sits between the cache0..cache3 instances and main memory inside the CPU top level.

---
 rtl/snoop_bus_if.sv | 37 +++
 rtl/snoop_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snoop_bus_if.sv
// Shared coherence bus tying the four caches and main memory to the snoop arbiter.
interface snoop_bus_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic [3:0]          req;
    logic [7:0]          req_op;
    logic [4*ADDR_W-1:0] req_addr;
    logic [3:0]          gnt;
    logic                snoop_valid;
    logic [1:0]          snoop_op;
    logic [ADDR_W-1:0]   snoop_addr;
    logic [1:0]          snoop_src;
    logic [3:0]          snoop_ack;
    logic [3:0]          snoop_shared;
    logic [3:0]          snoop_dirty;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ack;
    logic [3:0]          done;
    logic                done_shared;
    logic                done_from_cache;
    logic                timeout_err;

    // Arbiter (responder) side.
    modport slave (
        input  req, req_op, req_addr, snoop_ack, snoop_shared, snoop_dirty, mem_ack,
        output gnt, snoop_valid, snoop_op, snoop_addr, snoop_src, mem_req, mem_addr,
        output done, done_shared, done_from_cache, timeout_err
    );

    // Cache and memory side.
    modport master (
        output req, req_op, req_addr, snoop_ack, snoop_shared, snoop_dirty, mem_ack,
        input  gnt, snoop_valid, snoop_op, snoop_addr, snoop_src, mem_req, mem_addr,
        input  done, done_shared, done_from_cache, timeout_err
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin coherence bus arbiter: grants one cache, broadcasts the snoop, collects
// shared/dirty responses, falls back to memory and signals a one-cycle completion.
module snoop_bus_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned SNOOP_TIMEOUT = 16
) (
    input logic        clk,
    input logic        rst,
    snoop_bus_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SNOOP = 2'd1;
    localparam logic [1:0] MEM   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_UPGR = 2'b11;

    localparam int unsigned      CNT_W    = $clog2(SNOOP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SNOOP_TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        op_q, op_d;
    logic [1:0]        src_q, src_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        acked_q, acked_d;
    logic              shared_q, shared_d;
    logic              dirty_q, dirty_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mask_q, mask_d;
    logic              timeout_q, timeout_d;

    logic [3:0]        src_oh;
    logic [3:0]        eligible;
    logic [3:0]        new_ack;
    logic              found;
    logic [1:0]        pick;
    logic [1:0]        idx;
    logic [1:0]        pick_op;
    logic [ADDR_W-1:0] pick_addr;
    logic              all_acked;
    logic              expired;

    assign src_oh = 4'b0001 << src_q;

    // The proc just served is hidden for one IDLE cycle while it drops its request.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < 4; i++) begin
            eligible[i] = bus.req[i] && (bus.req_op[2*i +: 2] != 2'b00);
        end
        if (mask_q) begin
            eligible = eligible & ~src_oh;
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        pick_op   = '0;
        pick_addr = '0;
        for (int i = 0; i < 4; i++) begin
            if (pick == 2'(i)) begin
                pick_op   = bus.req_op[2*i +: 2];
                pick_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        op_d      = op_q;
        src_d     = src_q;
        addr_d    = addr_q;
        acked_d   = acked_q;
        shared_d  = shared_q;
        dirty_d   = dirty_q;
        cnt_d     = cnt_q;
        mask_d    = 1'b0;
        timeout_d = 1'b0;
        all_acked = 1'b0;
        expired   = 1'b0;
        new_ack   = bus.snoop_ack & ~acked_q & ~src_oh;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    op_d     = pick_op;
                    addr_d   = pick_addr;
                    src_d    = pick;
                    acked_d  = '0;
                    shared_d = 1'b0;
                    dirty_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = SNOOP;
                end
            end
            SNOOP: begin
                acked_d   = acked_q | new_ack;
                shared_d  = shared_q | (|(new_ack & bus.snoop_shared));
                dirty_d   = dirty_q | (|(new_ack & bus.snoop_dirty));
                all_acked = &(acked_d | src_oh);
                expired   = (cnt_q >= CNT_LAST);
                if (!expired) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (all_acked || expired) begin
                    timeout_d = !all_acked;
                    state_d   = (op_q == OP_UPGR || dirty_d) ? DONE : MEM;
                end
            end
            MEM: begin
                if (bus.mem_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ptr_d   = src_q + 2'd1;
                mask_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            op_q      <= '0;
            src_q     <= '0;
            addr_q    <= '0;
            acked_q   <= '0;
            shared_q  <= 1'b0;
            dirty_q   <= 1'b0;
            cnt_q     <= '0;
            mask_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            op_q      <= op_d;
            src_q     <= src_d;
            addr_q    <= addr_d;
            acked_q   <= acked_d;
            shared_q  <= shared_d;
            dirty_q   <= dirty_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt             = (state_q != IDLE) ? src_oh : 4'b0000;
    assign bus.snoop_valid     = (state_q == SNOOP);
    assign bus.snoop_op        = op_q;
    assign bus.snoop_addr      = addr_q;
    assign bus.snoop_src       = src_q;
    assign bus.mem_req         = (state_q == MEM);
    assign bus.mem_addr        = addr_q;
    assign bus.done            = (state_q == DONE) ? src_oh : 4'b0000;
    assign bus.done_shared     = (state_q == DONE) && (op_q == OP_RD) && shared_q;
    assign bus.done_from_cache = (state_q == DONE) && (op_q != OP_UPGR) && dirty_q;
    assign bus.timeout_err     = timeout_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed and randomized bench for snoop_bus_arbiter; expectations come from a
// transaction-level model of arbitration, snoop window and data source.
module tb_snoop_bus_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int          TMO    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snoop_bus_if #(.ADDR_W(ADDR_W)) bus ();

    snoop_bus_arbiter #(.ADDR_W(ADDR_W), .SNOOP_TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Responder behaviour: ack delay in SNOOP cycles (-1 never), flags, memory delay.
    int         ack_dly [4];
    logic [3:0] rsp_sh, rsp_dy;
    int         mem_dly;
    bit         hold_req, noise;
    int         drop_proc, drop_cyc;
    int         model_ptr;

    int                ob_src, ob_lat, ob_snoop_cyc, ob_to_n, ob_to_cyc;
    logic [3:0]        ob_done;
    logic              ob_dsh, ob_dfc, ob_mem, ob_hung, ob_bad;
    logic [1:0]        ob_op;
    logic [ADDR_W-1:0] ob_addr;

    task automatic set_req(input int p, input logic [1:0] op, input logic [ADDR_W-1:0] a);
        bus.req[p]                      = 1'b1;
        bus.req_op[2*p +: 2]            = op;
        bus.req_addr[p*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic cfg_rsp(input int d0, input int d1, input int d2, input int d3,
                           input logic [3:0] sh, input logic [3:0] dy, input int md);
        ack_dly[0] = d0; ack_dly[1] = d1; ack_dly[2] = d2; ack_dly[3] = d3;
        rsp_sh = sh; rsp_dy = dy; mem_dly = md;
    endtask

    function automatic int rr_pick(input logic [3:0] elig, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (elig[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic void predict(input int src, input logic [1:0] op, output bit e_to,
                                    output bit e_mem, output bit e_dsh, output bit e_dfc,
                                    output int e_lat);
        bit all_in = 1'b1;
        bit sh = 1'b0;
        bit dy = 1'b0;
        int win = 0;
        for (int j = 0; j < 4; j++) begin
            if (j != src) begin
                if (ack_dly[j] >= 0 && ack_dly[j] < TMO) begin
                    sh = sh | rsp_sh[j];
                    dy = dy | rsp_dy[j];
                    if (ack_dly[j] + 1 > win) win = ack_dly[j] + 1;
                end else begin
                    all_in = 1'b0;
                end
            end
        end
        if (!all_in) win = TMO;
        e_to  = !all_in;
        e_mem = (op != 2'b11) && !dy;
        e_dfc = (op != 2'b11) && dy;
        e_dsh = (op == 2'b01) && sh;
        e_lat = win + (e_mem ? mem_dly + 1 : 0);
    endfunction

    // Plays the caches and memory for one transaction, recording what the arbiter did.
    task automatic do_txn();
        int st = -1;
        int mcnt = 0;
        logic [3:0] ack, sh, dy;
        ob_src = -1; ob_done = '0; ob_dsh = 1'b0; ob_dfc = 1'b0; ob_mem = 1'b0;
        ob_hung = 1'b1; ob_bad = 1'b0; ob_snoop_cyc = 0; ob_lat = -1;
        ob_to_n = 0; ob_to_cyc = -1; ob_op = '0; ob_addr = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (drop_proc >= 0 && c == drop_cyc) bus.req[drop_proc] = 1'b0;
            if (bus.snoop_valid) begin
                if (st < 0) begin
                    st = c; ob_src = int'(bus.snoop_src); ob_op = bus.snoop_op;
                    ob_addr = bus.snoop_addr;
                end
                ob_snoop_cyc++;
                if (bus.gnt !== (4'b0001 << ob_src) || bus.mem_req || bus.done != 4'b0)
                    ob_bad = 1'b1;
            end else if (st < 0 && bus.gnt !== 4'b0) begin
                ob_bad = 1'b1;
            end
            if (bus.mem_req) begin
                ob_mem = 1'b1;
                if (st < 0 || bus.mem_addr !== ob_addr || bus.gnt !== (4'b0001 << ob_src))
                    ob_bad = 1'b1;
            end
            if (bus.timeout_err) begin
                ob_to_n++;
                if (ob_to_cyc < 0) ob_to_cyc = c - st;
            end
            if (bus.done != 4'b0) begin
                ob_done = bus.done; ob_dsh = bus.done_shared; ob_dfc = bus.done_from_cache;
                ob_lat = c - st; ob_hung = 1'b0;
                if (st < 0 || bus.gnt !== bus.done) ob_bad = 1'b1;
                if (!hold_req && ob_src >= 0) bus.req[ob_src] = 1'b0;
                bus.snoop_ack = '0; bus.snoop_shared = '0; bus.snoop_dirty = '0;
                bus.mem_ack = 1'b0;
                break;
            end
            if (bus.done_shared || bus.done_from_cache) ob_bad = 1'b1;
            ack = '0; sh = '0; dy = '0;
            if (bus.snoop_valid) begin
                for (int j = 0; j < 4; j++) begin
                    if (j != ob_src && (c - st) == ack_dly[j]) begin
                        ack[j] = 1'b1; sh[j] = rsp_sh[j]; dy[j] = rsp_dy[j];
                    end else if (noise && (j == ob_src || (ack_dly[j] >= 0 &&
                                 (c - st) > ack_dly[j])) && $urandom_range(1, 0) == 1) begin
                        ack[j] = 1'b1; sh[j] = 1'b1; dy[j] = 1'b1;
                    end
                end
            end
            bus.snoop_ack = ack; bus.snoop_shared = sh; bus.snoop_dirty = dy;
            if (bus.mem_req) begin
                bus.mem_ack = (mcnt == mem_dly);
                mcnt++;
            end else begin
                bus.mem_ack = noise ? ($urandom_range(1, 0) == 1) : 1'b0;
            end
        end
        if (ob_hung) begin
            bus.req = '0;
            $display("FAIL txn_timeout: no done within 200 cycles, src=%0d", ob_src);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(1, 2'b01, 32'h1234);
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.gnt, bus.done, bus.snoop_valid, bus.mem_req, bus.timeout_err,
             bus.done_shared, bus.done_from_cache} !== 13'd0) begin
            errors++;
            $display("FAIL reset_ctrl: gnt=%b done=%b sv=%b mr=%b to=%b want all 0",
                     bus.gnt, bus.done, bus.snoop_valid, bus.mem_req, bus.timeout_err);
        end
        checks++;
        if ({bus.snoop_op, bus.snoop_src, bus.snoop_addr} !== '0) begin
            errors++;
            $display("FAIL reset_snoop: op=%0d src=%0d addr=%h want 0", bus.snoop_op,
                     bus.snoop_src, bus.snoop_addr);
        end
        bus.req = '0; bus.req_op = '0; rst = 1'b0; model_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        for (int p = 0; p < 4; p++) set_req(p, 2'b01, 32'(p + 1) << 8);
        cfg_rsp(0, 0, 0, 0, 4'h0, 4'h0, 2);
        for (int k = 0; k < 4; k++) begin
            do_txn();
            checks++;
            if (ob_src != k || ob_done !== (4'b0001 << k)) begin
                errors++;
                $display("FAIL rr_order: src=%0d done=%b want proc %0d", ob_src, ob_done, k);
            end
            checks++;
            if ({ob_dsh, ob_dfc} !== 2'b00 || ob_mem !== 1'b1 || ob_bad !== 1'b0) begin
                errors++;
                $display("FAIL rr_flags: dsh=%b dfc=%b mem=%b bad=%b want 0 0 1 0",
                         ob_dsh, ob_dfc, ob_mem, ob_bad);
            end
            checks++;
            if (ob_lat != 4 || ob_addr !== (32'(k + 1) << 8)) begin
                errors++;
                $display("FAIL rr_lat_addr: lat=%0d addr=%h want 4 %h", ob_lat, ob_addr,
                         32'(k + 1) << 8);
            end
        end
        model_ptr = 0;
    endtask

    task automatic test_dirty_hit();
        set_req(1, 2'b01, 32'h40);
        cfg_rsp(0, 0, 0, 0, 4'b0100, 4'b0100, 0);
        do_txn();
        checks++;
        if (ob_done !== 4'b0010 || ob_dfc !== 1'b1 || ob_dsh !== 1'b1) begin
            errors++;
            $display("FAIL dirty_hit: done=%b dfc=%b dsh=%b want 0010 1 1", ob_done, ob_dfc,
                     ob_dsh);
        end
        checks++;
        if (ob_mem !== 1'b0 || ob_lat != 1 || ob_bad !== 1'b0 || ob_addr !== 32'h40) begin
            errors++;
            $display("FAIL dirty_hit_path: mem=%b lat=%0d bad=%b addr=%h want 0 1 0 40",
                     ob_mem, ob_lat, ob_bad, ob_addr);
        end
        model_ptr = 2;
    endtask

    task automatic test_upgrade();
        set_req(3, 2'b11, 32'h80);
        cfg_rsp(0, 2, 1, -1, 4'b0111, 4'b0000, 0);
        do_txn();
        checks++;
        if (ob_done !== 4'b1000 || ob_lat != 3 || ob_op !== 2'b11) begin
            errors++;
            $display("FAIL upgr: done=%b lat=%0d op=%0d want 1000 3 3", ob_done, ob_lat, ob_op);
        end
        checks++;
        if (ob_dsh !== 1'b0 || ob_dfc !== 1'b0 || ob_mem !== 1'b0 || ob_to_n != 0) begin
            errors++;
            $display("FAIL upgr_flags: dsh=%b dfc=%b mem=%b to=%0d want 0 0 0 0", ob_dsh,
                     ob_dfc, ob_mem, ob_to_n);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 4'b0 || bus.gnt !== 4'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b gnt=%b want 0 0 after DONE", bus.done, bus.gnt);
        end
        model_ptr = 0;
    endtask

    task automatic test_timeout();
        set_req(0, 2'b10, 32'hC0);
        cfg_rsp(0, 0, -1, 0, 4'h0, 4'h0, 1);
        do_txn();
        checks++;
        if (ob_to_n != 1 || ob_to_cyc != TMO || ob_snoop_cyc != TMO) begin
            errors++;
            $display("FAIL timeout: pulses=%0d at=%0d snoop_cycles=%0d want 1 %0d %0d",
                     ob_to_n, ob_to_cyc, ob_snoop_cyc, TMO, TMO);
        end
        checks++;
        if (ob_mem !== 1'b1 || ob_done !== 4'b0001 || ob_lat != TMO + 2 || ob_dfc !== 1'b0) begin
            errors++;
            $display("FAIL timeout_mem: mem=%b done=%b lat=%0d dfc=%b want 1 0001 %0d 0",
                     ob_mem, ob_done, ob_lat, ob_dfc, TMO + 2);
        end
        model_ptr = 1;
    endtask

    task automatic test_reset_mid();
        bit got_mem = 1'b0;
        bit stray = 1'b0;
        set_req(2, 2'b01, 32'h200);
        cfg_rsp(0, 0, 0, 0, 4'h0, 4'h0, 0);
        do_txn();
        set_req(3, 2'b01, 32'h300);
        for (int c = 0; c < 40 && !got_mem; c++) begin
            @(negedge clk);
            if (bus.mem_req) got_mem = 1'b1;
            else bus.snoop_ack = bus.snoop_valid ? 4'b1111 : 4'b0000;
        end
        bus.snoop_ack = '0;
        checks++;
        if (!got_mem) begin
            errors++;
            $display("FAIL rst_mid_setup: mem_req=0 want 1 before reset");
        end
        rst = 1'b1; bus.mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.gnt, bus.done, bus.snoop_valid, bus.mem_req, bus.timeout_err,
             bus.done_shared, bus.done_from_cache, bus.snoop_src, bus.snoop_addr} !== '0) begin
            errors++;
            $display("FAIL rst_mid: gnt=%b done=%b mr=%b src=%0d addr=%h want all 0",
                     bus.gnt, bus.done, bus.mem_req, bus.snoop_src, bus.snoop_addr);
        end
        rst = 1'b0; bus.mem_ack = 1'b0; bus.req = '0; bus.req_op = '0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done != 4'b0 || bus.gnt != 4'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL rst_mid_nodone: stray done/gnt=1 want 0 after reset");
        end
        model_ptr = 0;
        set_req(2, 2'b01, 32'h220);
        set_req(3, 2'b01, 32'h330);
        do_txn();
        checks++;
        if (ob_src != 2 || ob_addr !== 32'h220) begin
            errors++;
            $display("FAIL rst_ptr: src=%0d addr=%h want 2 220", ob_src, ob_addr);
        end
        do_txn();
        checks++;
        if (ob_src != 3) begin
            errors++;
            $display("FAIL rst_ptr_next: src=%0d want 3", ob_src);
        end
        model_ptr = 0;
    endtask

    task automatic test_back_to_back();
        set_req(2, 2'b01, 32'h2000);
        set_req(3, 2'b10, 32'h3000);
        cfg_rsp(0, 0, 0, 0, 4'h0, 4'h0, 0);
        hold_req = 1'b1;
        do_txn();
        hold_req = 1'b0;
        checks++;
        if (ob_src != 2) begin
            errors++;
            $display("FAIL b2b_first: src=%0d want 2", ob_src);
        end
        drop_proc = 2; drop_cyc = 1;
        do_txn();
        drop_proc = -1;
        checks++;
        if (ob_src != 3 || ob_done !== 4'b1000 || ob_op !== 2'b10) begin
            errors++;
            $display("FAIL b2b_second: src=%0d done=%b op=%0d want 3 1000 2", ob_src, ob_done,
                     ob_op);
        end
        model_ptr = 0;
    endtask

    task automatic test_mask();
        bit busy = 1'b0;
        set_req(1, 2'b01, 32'h1100);
        cfg_rsp(0, 0, 0, 0, 4'h0, 4'h0, 0);
        hold_req = 1'b1;
        do_txn();
        hold_req = 1'b0;
        checks++;
        if (ob_src != 1) begin
            errors++;
            $display("FAIL mask_setup: src=%0d want 1", ob_src);
        end
        @(negedge clk);
        @(negedge clk);
        bus.req = '0; bus.req_op = '0;
        if (bus.snoop_valid || bus.gnt != 4'b0) busy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.snoop_valid || bus.gnt != 4'b0) busy = 1'b1;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL mask_reserve: proc 1 re-served=1 want 0");
        end
        model_ptr = 2;
    endtask

    task automatic test_random();
        logic [3:0]        elig;
        logic [1:0]        ops [4];
        logic [ADDR_W-1:0] adr [4];
        int e_src, e_lat;
        bit e_to, e_mem, e_dsh, e_dfc;
        noise = 1'b1;
        for (int t = 0; t < 30; t++) begin
            bus.req = '0; bus.req_op = '0;
            elig = '0;
            while (elig == 4'b0) begin
                for (int p = 0; p < 4; p++) begin
                    ops[p] = 2'($urandom_range(3, 1));
                    adr[p] = $urandom;
                    if ($urandom_range(1, 0) == 1) begin
                        set_req(p, ops[p], adr[p]);
                        elig[p] = 1'b1;
                    end else if ($urandom_range(3, 0) == 0) begin
                        bus.req[p] = 1'b1;
                    end
                end
            end
            for (int j = 0; j < 4; j++) begin
                ack_dly[j] = ($urandom_range(9, 0) == 0) ? -1 : int'($urandom_range(5, 0));
            end
            rsp_sh  = 4'($urandom);
            rsp_dy  = 4'($urandom) & 4'($urandom);
            mem_dly = int'($urandom_range(3, 0));
            e_src = rr_pick(elig, model_ptr);
            predict(e_src, ops[e_src], e_to, e_mem, e_dsh, e_dfc, e_lat);
            do_txn();
            checks++;
            if (ob_src != e_src || ob_done !== (4'b0001 << e_src) || ob_op !== ops[e_src] ||
                ob_addr !== adr[e_src]) begin
                errors++;
                $display("FAIL rnd_grant[%0d]: src=%0d done=%b op=%0d addr=%h want %0d %0d %h",
                         t, ob_src, ob_done, ob_op, ob_addr, e_src, ops[e_src], adr[e_src]);
            end
            checks++;
            if (ob_dsh !== e_dsh || ob_dfc !== e_dfc || ob_mem !== e_mem ||
                ob_to_n != int'(e_to)) begin
                errors++;
                $display("FAIL rnd_result[%0d]: dsh=%b dfc=%b mem=%b to=%0d want %b %b %b %0d",
                         t, ob_dsh, ob_dfc, ob_mem, ob_to_n, e_dsh, e_dfc, e_mem, e_to);
            end
            checks++;
            if (ob_lat != e_lat || ob_bad !== 1'b0) begin
                errors++;
                $display("FAIL rnd_timing[%0d]: lat=%0d bad=%b want %0d 0", t, ob_lat, ob_bad,
                         e_lat);
            end
            model_ptr = (e_src + 1) % 4;
        end
        noise = 1'b0;
        bus.req = '0; bus.req_op = '0;
    endtask

    initial begin
        bus.req = '0; bus.req_op = '0; bus.req_addr = '0;
        bus.snoop_ack = '0; bus.snoop_shared = '0; bus.snoop_dirty = '0; bus.mem_ack = 1'b0;
        rst = 1'b1;
        hold_req = 1'b0; noise = 1'b0; drop_proc = -1; drop_cyc = 0; model_ptr = 0;
        cfg_rsp(0, 0, 0, 0, 4'h0, 4'h0, 0);
        test_reset();
        test_round_robin();
        test_dirty_hit();
        test_upgrade();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_mask();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
